div_unit: RTL and testbench

- Multi-cycle 32-bit radix-2 divider in the EX stage of mycpu.
- Consumes the decoded `EXE_DIV_OP` / `EXE_DIVU_OP` alucontrol codes from defines.vh and produces the MIPS HI (remainder) and LO (quotient) results.
- Raises a stall to the hazard unit while it iterates.
- Pulses ready for one cycle when the HI/LO result is valid, so the pipeline can write the hilo register.

---
 rtl/div_unit.sv | 156 +++++++++++++++
 tb/tb_div_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for the EX stage: produces HI (remainder)
// and LO (quotient) for signed/unsigned divide, stalling the pipeline while it iterates.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [7:0]       alucontrol,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             stall_div,
    output logic             ready,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // Decoded ALU op codes shared with the rest of the EX stage.
    localparam logic [7:0] DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] DIVU_OP = 8'b0001_1011;
    localparam int         CW      = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIV_ON  = 2'd1,
        BY_ZERO = 2'd2,
        DIV_END = 2'd3
    } state_t;

    state_t               state_reg,   state_next;
    logic [CW-1:0]        counter_reg, counter_next;
    logic [2*WIDTH:0]     work_reg,    work_next;
    logic [WIDTH-1:0]     divisor_reg, divisor_next;
    logic [WIDTH-1:0]     a_reg,       a_next;
    logic                 neg_q_reg,   neg_q_next;
    logic                 neg_r_reg,   neg_r_next;
    logic [WIDTH-1:0]     hi_reg,      hi_next;
    logic [WIDTH-1:0]     lo_reg,      lo_next;

    logic                 is_div_op;
    logic                 op_signed;
    logic                 accept;
    logic [WIDTH-1:0]     a_abs;
    logic [WIDTH-1:0]     b_abs;
    logic [2*WIDTH:0]     shifted;
    logic [WIDTH:0]       trial;
    logic [2*WIDTH:0]     step;
    logic [WIDTH-1:0]     quo_u;
    logic [WIDTH-1:0]     rem_u;
    logic [WIDTH-1:0]     q_final;
    logic [WIDTH-1:0]     r_final;

    assign is_div_op = (alucontrol == DIV_OP) || (alucontrol == DIVU_OP);
    assign op_signed = (alucontrol == DIV_OP);
    assign accept    = (state_reg == IDLE) && start && !flush && is_div_op;

    // Signed divide runs on magnitudes; signs are re-applied when the result is written.
    assign a_abs = (op_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign b_abs = (op_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

    // One restoring step: shift, trial-subtract, keep if non-negative (bit WIDTH clear).
    assign shifted = {work_reg[2*WIDTH-1:0], 1'b0};
    assign trial   = shifted[2*WIDTH:WIDTH] - {1'b0, divisor_reg};
    assign step    = trial[WIDTH] ? shifted : {trial, shifted[WIDTH-1:1], 1'b1};

    assign quo_u   = step[WIDTH-1:0];
    assign rem_u   = step[2*WIDTH-1:WIDTH];
    assign q_final = neg_q_reg ? (~quo_u + 1'b1) : quo_u;
    assign r_final = neg_r_reg ? (~rem_u + 1'b1) : rem_u;

    always_comb begin
        state_next   = state_reg;
        counter_next = counter_reg;
        work_next    = work_reg;
        divisor_next = divisor_reg;
        a_next       = a_reg;
        neg_q_next   = neg_q_reg;
        neg_r_next   = neg_r_reg;
        hi_next      = hi_reg;
        lo_next      = lo_reg;

        if (flush) begin
            state_next   = IDLE;
            counter_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        work_next    = {{(WIDTH+1){1'b0}}, a_abs};
                        divisor_next = b_abs;
                        a_next       = a;
                        neg_q_next   = op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r_next   = op_signed && a[WIDTH-1];
                        counter_next = '0;
                        state_next   = (b == '0) ? BY_ZERO : DIV_ON;
                    end
                end
                DIV_ON: begin
                    work_next    = step;
                    counter_next = counter_reg + 1'b1;
                    if (counter_reg == CW'(WIDTH - 1)) begin
                        hi_next      = r_final;
                        lo_next      = q_final;
                        counter_next = '0;
                        state_next   = DIV_END;
                    end
                end
                BY_ZERO: begin
                    hi_next    = a_reg;
                    lo_next    = '1;
                    state_next = DIV_END;
                end
                DIV_END: begin
                    // EX advances at the end of this cycle, so a still-high start is stale.
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg   <= IDLE;
            counter_reg <= '0;
            work_reg    <= '0;
            divisor_reg <= '0;
            a_reg       <= '0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
            hi_reg      <= '0;
            lo_reg      <= '0;
        end else begin
            state_reg   <= state_next;
            counter_reg <= counter_next;
            work_reg    <= work_next;
            divisor_reg <= divisor_next;
            a_reg       <= a_next;
            neg_q_reg   <= neg_q_next;
            neg_r_reg   <= neg_r_next;
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
        end
    end

    // Stall rises combinationally in the arrival cycle; a pipeline in reset is never stalled.
    assign stall_div = resetn && !flush &&
                       (accept || (state_reg == DIV_ON) || (state_reg == BY_ZERO));
    assign ready     = (state_reg == DIV_END);
    assign hi        = hi_reg;
    assign lo        = lo_reg;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random divides
// compared against a plain-arithmetic reference model.
module tb_div_unit;

    localparam logic [7:0] DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] DIVU_OP = 8'b0001_1011;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [7:0]  alucontrol;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        stall_div;
    logic        ready;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_err = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .alucontrol (alucontrol),
        .a          (a),
        .b          (b),
        .flush      (flush),
        .stall_div  (stall_div),
        .ready      (ready),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: MIPS divide semantics computed with ordinary integer arithmetic.
    task automatic model(input logic [7:0] op, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] eh, output logic [31:0] el);
        int sx;
        int sy;
        if (y == 32'd0) begin
            el = 32'hFFFF_FFFF;
            eh = x;
        end else if (op == DIVU_OP) begin
            el = x / y;
            eh = x % y;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            el = 32'h8000_0000;
            eh = 32'd0;
        end else begin
            sx = x;
            sy = y;
            el = sx / sy;
            eh = sx % sy;
        end
    endtask

    // Issue one divide, hold start until ready (as a stalled EX would), then release.
    task automatic run_div(input logic [7:0] op, input logic [31:0] da, input logic [31:0] db,
                           input string tag);
        logic [31:0] eh;
        logic [31:0] el;
        int exp_lat;
        int lat;
        int stall_low;
        bit got_ready;
        model(op, da, db, eh, el);
        exp_lat   = (db == 32'd0) ? 2 : 33;
        lat       = 0;
        stall_low = 0;
        got_ready = 0;
        @(negedge clk);
        start      = 1'b1;
        alucontrol = op;
        a          = da;
        b          = db;
        #1;
        check({tag, "_stall_accept"}, {31'd0, stall_div}, 32'd1);
        while (!got_ready && lat < 40) begin
            @(negedge clk);
            #1;
            lat++;
            if (ready) got_ready = 1;
            else if (!stall_div) stall_low++;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_stall_gaps"}, stall_low, 0);
        check({tag, "_stall_at_ready"}, {31'd0, stall_div}, 32'd0);
        check({tag, "_lo"}, lo, el);
        check({tag, "_hi"}, hi, eh);
        $display("div op=%02h a=%08h b=%08h -> lo=%08h hi=%08h lat=%0d", op, da, db, lo, hi, lat);
        @(negedge clk);
        start = 1'b0;
        #1;
        check({tag, "_single_ready"}, {31'd0, ready}, 32'd0);
        check({tag, "_no_relaunch"}, {31'd0, stall_div}, 32'd0);
    endtask

    initial begin
        int pulses;
        logic [7:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        resetn     = 1'b0;
        start      = 1'b0;
        alucontrol = 8'd0;
        a          = 32'd0;
        b          = 32'd0;
        flush      = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_stall", {31'd0, stall_div}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        run_div(DIVU_OP, 32'd100, 32'd7, "divu_100_7");
        run_div(DIV_OP, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        run_div(DIV_OP, 32'd7, 32'hFFFF_FFFE, "div_7_m2");
        run_div(DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_div(DIVU_OP, 32'h8000_0000, 32'hFFFF_FFFF, "divu_big");
        run_div(DIVU_OP, 32'h1234, 32'd0, "divu_by0");
        run_div(DIV_OP, 32'hFFFF_FF00, 32'd0, "div_by0");

        // Flush at iteration 10: no result, previous hi/lo retained.
        run_div(DIVU_OP, 32'd100, 32'd7, "pre_flush");
        @(negedge clk);
        start      = 1'b1;
        alucontrol = DIVU_OP;
        a          = 32'd1000;
        b          = 32'd3;
        repeat (11) @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush_stall", {31'd0, stall_div}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        start = 1'b0;
        #1;
        check("flush_no_ready", {31'd0, ready}, 32'd0);
        check("flush_idle", {31'd0, stall_div}, 32'd0);
        check("flush_hi_kept", hi, 32'd2);
        check("flush_lo_kept", lo, 32'd14);
        run_div(DIVU_OP, 32'd1000, 32'd3, "post_flush");

        // Asynchronous reset at iteration 20.
        @(negedge clk);
        start      = 1'b1;
        alucontrol = DIVU_OP;
        a          = 32'd100;
        b          = 32'd7;
        repeat (21) @(negedge clk);
        resetn = 1'b0;
        start  = 1'b0;
        #1;
        check("midrst_hi", hi, 32'd0);
        check("midrst_lo", lo, 32'd0);
        check("midrst_ready", {31'd0, ready}, 32'd0);
        check("midrst_stall", {31'd0, stall_div}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (ready || stall_div) pulses++;
        end
        check("midrst_quiet", pulses, 0);

        // Non-divide op with start high must be inert.
        start      = 1'b1;
        alucontrol = 8'h00;
        a          = 32'd50;
        b          = 32'd5;
        pulses     = 0;
        repeat (4) begin
            @(negedge clk);
            #1;
            if (ready || stall_div) pulses++;
        end
        check("badop_inert", pulses, 0);

        // Flush in the arrival cycle prevents accept.
        @(negedge clk);
        alucontrol = DIV_OP;
        flush      = 1'b1;
        #1;
        check("flush_start_stall", {31'd0, stall_div}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        start = 1'b0;
        #1;
        check("flush_start_noacc", {31'd0, stall_div}, 32'd0);

        for (int i = 0; i < 20; i++) begin
            rop = ($urandom_range(0, 1) == 0) ? DIV_OP : DIVU_OP;
            ra  = $urandom;
            case ($urandom_range(0, 4))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 20);
                2:       rb = 32'hFFFF_FFFF - $urandom_range(0, 20);
                default: rb = $urandom;
            endcase
            run_div(rop, ra, rb, $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
